// File: rtl/rf_arbiter_params.sv
// Shared types and defaults for the register-file write arbiter.
package rf_arbiter_params;

    localparam int FIFO_DEPTH_DEFAULT   = 2;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    // One register-file write: target register, byte strobe, payload.
    typedef struct packed {
        logic [4:0]  address;
        logic [3:0]  strobe;
        logic [31:0] data;
    } rf_write_req_t;

endpackage

// File: rtl/rf_pending_fifo.sv
// Pending queue for long-latency results: storage, pointers, occupancy and
// the OR-mask of destination registers still waiting to be written.
module rf_pending_fifo
    import rf_arbiter_params::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  rf_write_req_t push_req,
    input  logic          pop,
    output rf_write_req_t head,
    output logic          full,
    output logic          empty,
    output logic [31:0]   pending_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    rf_write_req_t   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; validity is tracked by the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(PW'(i) - rd_ptr)} < count)
                pending_mask[mem[i].address] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between the writeback stage and a
// long-latency unit, with a bounded-starvation hold on WB.
// Optional feature: define RF_ARB_BYPASS_EN to let an LU result go straight
// to the write port when the queue is empty and WB is not writing.
module rf_write_arbiter
    import rf_arbiter_params::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_write_enabled,
    input  logic [4:0]  wb_write_address,
    input  logic [3:0]  wb_write_strobe,
    input  logic [31:0] wb_write_data,
    output logic        wb_hold,
    input  logic        lu_valid,
    input  logic [4:0]  lu_write_address,
    input  logic [31:0] lu_write_data,
    output logic        lu_ready,
    output logic        rf_write_enabled,
    output logic [4:0]  rf_write_address,
    output logic [3:0]  rf_write_strobe,
    output logic [31:0] rf_write_data,
    output logic [31:0] pending_mask
);

    logic          ready_q;
    logic [3:0]    starve_cnt;
    logic          q_full, q_empty;
    rf_write_req_t q_head, lu_req;
    logic          lu_fire, wb_grant, lu_grant, bypass, push, pop;

    assign lu_req   = '{address: lu_write_address, strobe: 4'b1111, data: lu_write_data};
    assign lu_ready = ready_q & ~q_full;
    assign lu_fire  = lu_valid & lu_ready;
    assign wb_hold  = ~q_empty & (starve_cnt == 4'(STARVE_LIMIT));
    assign wb_grant = wb_write_enabled & ~wb_hold;
    assign lu_grant = ~q_empty & (~wb_write_enabled | wb_hold);

`ifdef RF_ARB_BYPASS_EN
    assign bypass = lu_fire & q_empty & ~wb_write_enabled & (lu_write_address != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // r0 results complete the handshake but are dropped here.
    assign push = lu_fire & (lu_write_address != 5'd0) & ~bypass;
    assign pop  = lu_grant;

    rf_pending_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .push         (push),
        .push_req     (lu_req),
        .pop          (pop),
        .head         (q_head),
        .full         (q_full),
        .empty        (q_empty),
        .pending_mask (pending_mask)
    );

    // lu_ready stays low during reset and rises on the first edge after it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    // Count WB wins while LU waits; saturation is what raises wb_hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (q_empty || lu_grant)
            starve_cnt <= '0;
        else if (wb_grant && starve_cnt != 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Write-port mux; outputs follow the granted source in the same cycle.
    always_comb begin
        rf_write_enabled = 1'b0;
        rf_write_address = '0;
        rf_write_strobe  = '0;
        rf_write_data    = '0;
        if (reset_n) begin
            if (wb_grant) begin
                rf_write_enabled = 1'b1;
                rf_write_address = wb_write_address;
                rf_write_strobe  = wb_write_strobe;
                rf_write_data    = wb_write_data;
            end else if (lu_grant) begin
                rf_write_enabled = 1'b1;
                rf_write_address = q_head.address;
                rf_write_strobe  = 4'b1111;
                rf_write_data    = q_head.data;
            end else if (bypass) begin
                rf_write_enabled = 1'b1;
                rf_write_address = lu_req.address;
                rf_write_strobe  = lu_req.strobe;
                rf_write_data    = lu_req.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
// Inputs change just after a falling edge; outputs are sampled 1 ns later.
module tb_rf_write_arbiter;

    logic        clock, reset_n;
    logic        wb_write_enabled;
    logic [4:0]  wb_write_address;
    logic [3:0]  wb_write_strobe;
    logic [31:0] wb_write_data;
    logic        wb_hold;
    logic        lu_valid;
    logic [4:0]  lu_write_address;
    logic [31:0] lu_write_data;
    logic        lu_ready;
    logic        rf_write_enabled;
    logic [4:0]  rf_write_address;
    logic [3:0]  rf_write_strobe;
    logic [31:0] rf_write_data;
    logic [31:0] pending_mask;

    int checks = 0;
    int passed = 0;

    rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .wb_write_enabled (wb_write_enabled),
        .wb_write_address (wb_write_address),
        .wb_write_strobe  (wb_write_strobe),
        .wb_write_data    (wb_write_data),
        .wb_hold          (wb_hold),
        .lu_valid         (lu_valid),
        .lu_write_address (lu_write_address),
        .lu_write_data    (lu_write_data),
        .lu_ready         (lu_ready),
        .rf_write_enabled (rf_write_enabled),
        .rf_write_address (rf_write_address),
        .rf_write_strobe  (rf_write_strobe),
        .rf_write_data    (rf_write_data),
        .pending_mask     (pending_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic wb_busy();
        wb_write_enabled = 1'b1; wb_write_address = 5'd3;
        wb_write_strobe = 4'b0011; wb_write_data = 32'hAAAA;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wb_busy(); lu_valid = 1'b1; lu_write_address = 5'd4; lu_write_data = 32'h1;
        @(negedge clock); #1;
        checks++; if (rf_write_enabled !== 1'b0) $display("FAIL reset_rf_we got %b want 0", rf_write_enabled); else passed++;
        checks++; if (lu_ready !== 1'b0) $display("FAIL reset_lu_ready got %b want 0", lu_ready); else passed++;
        checks++; if (wb_hold !== 1'b0) $display("FAIL reset_hold got %b want 0", wb_hold); else passed++;
        checks++; if (pending_mask !== 32'h0) $display("FAIL reset_mask got %h want 0", pending_mask); else passed++;
        wb_write_enabled = 1'b0; lu_valid = 1'b0; reset_n = 1'b1; #1;
        checks++; if (lu_ready !== 1'b0) $display("FAIL reset_ready_before_edge got %b want 0", lu_ready); else passed++;
        @(negedge clock); #1;
        checks++; if (lu_ready !== 1'b1) $display("FAIL reset_ready_after_edge got %b want 1", lu_ready); else passed++;
    endtask

`ifndef RF_ARB_BYPASS_EN
    task automatic test_lu_basic();
        wb_write_enabled = 1'b0; lu_valid = 1'b1; lu_write_address = 5'd5; lu_write_data = 32'h1234; #1;
        checks++; if (rf_write_enabled !== 1'b0) $display("FAIL basic_no_same_cycle got %b want 0", rf_write_enabled); else passed++;
        @(negedge clock); lu_valid = 1'b0; #1;
        checks++; if (rf_write_enabled !== 1'b1) $display("FAIL basic_we got %b want 1", rf_write_enabled); else passed++;
        checks++; if (rf_write_address !== 5'd5) $display("FAIL basic_addr got %0d want 5", rf_write_address); else passed++;
        checks++; if (rf_write_data !== 32'h1234) $display("FAIL basic_data got %h want 1234", rf_write_data); else passed++;
        checks++; if (rf_write_strobe !== 4'hF) $display("FAIL basic_strobe got %h want f", rf_write_strobe); else passed++;
        checks++; if (pending_mask !== 32'h20) $display("FAIL basic_mask got %h want 20", pending_mask); else passed++;
        @(negedge clock); #1;
        checks++; if (rf_write_enabled !== 1'b0) $display("FAIL basic_idle_we got %b want 0", rf_write_enabled); else passed++;
        checks++; if (pending_mask !== 32'h0) $display("FAIL basic_mask_clear got %h want 0", pending_mask); else passed++;
    endtask
`else
    task automatic test_bypass();
        wb_write_enabled = 1'b0; lu_valid = 1'b1; lu_write_address = 5'd7; lu_write_data = 32'hBEEF; #1;
        checks++; if (rf_write_enabled !== 1'b1) $display("FAIL bypass_we got %b want 1", rf_write_enabled); else passed++;
        checks++; if (rf_write_address !== 5'd7) $display("FAIL bypass_addr got %0d want 7", rf_write_address); else passed++;
        checks++; if (rf_write_data !== 32'hBEEF) $display("FAIL bypass_data got %h want beef", rf_write_data); else passed++;
        checks++; if (pending_mask !== 32'h0) $display("FAIL bypass_mask got %h want 0", pending_mask); else passed++;
        @(negedge clock); lu_valid = 1'b0; #1;
        checks++; if (rf_write_enabled !== 1'b0) $display("FAIL bypass_after_we got %b want 0", rf_write_enabled); else passed++;
        checks++; if (pending_mask !== 32'h0) $display("FAIL bypass_after_mask got %h want 0", pending_mask); else passed++;
    endtask
`endif

    task automatic test_starve();
        wb_busy(); lu_valid = 1'b1; lu_write_address = 5'd9; lu_write_data = 32'h55; #1;
        checks++; if (rf_write_address !== 5'd3) $display("FAIL starve_c0_addr got %0d want 3", rf_write_address); else passed++;
        @(negedge clock); lu_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++; if (wb_hold !== 1'b0 || rf_write_address !== 5'd3)
                $display("FAIL starve_c%0d got hold=%b addr=%0d want hold=0 addr=3", c, wb_hold, rf_write_address); else passed++;
            @(negedge clock);
        end
        #1;
        checks++; if (wb_hold !== 1'b1) $display("FAIL starve_hold got %b want 1", wb_hold); else passed++;
        checks++; if (rf_write_address !== 5'd9 || rf_write_data !== 32'h55 || rf_write_strobe !== 4'hF)
            $display("FAIL starve_lu_write got %0d/%h/%h want 9/55/f", rf_write_address, rf_write_data, rf_write_strobe); else passed++;
        @(negedge clock); #1;
        checks++; if (wb_hold !== 1'b0 || rf_write_address !== 5'd3)
            $display("FAIL starve_after got hold=%b addr=%0d want hold=0 addr=3", wb_hold, rf_write_address); else passed++;
        checks++; if (pending_mask !== 32'h0) $display("FAIL starve_mask got %h want 0", pending_mask); else passed++;
    endtask

    task automatic test_back_to_back();
        wb_busy(); lu_valid = 1'b1; lu_write_address = 5'd10; lu_write_data = 32'd1; #1;
        checks++; if (lu_ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", lu_ready); else passed++;
        @(negedge clock); lu_write_address = 5'd11; lu_write_data = 32'd2; #1;
        checks++; if (lu_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", lu_ready); else passed++;
        @(negedge clock); lu_write_address = 5'd12; lu_write_data = 32'd3; #1;
        checks++; if (lu_ready !== 1'b0) $display("FAIL b2b_ready2 got %b want 0", lu_ready); else passed++;
        @(negedge clock); #1;
        checks++; if (pending_mask !== 32'h0000_0C00) $display("FAIL b2b_mask_full got %h want 00000c00", pending_mask); else passed++;
        @(negedge clock); #1;
        checks++; if (lu_ready !== 1'b0 || wb_hold !== 1'b0) $display("FAIL b2b_c4 got ready=%b hold=%b want 0/0", lu_ready, wb_hold); else passed++;
        @(negedge clock); #1;
        checks++; if (wb_hold !== 1'b1 || lu_ready !== 1'b0) $display("FAIL b2b_c5 got hold=%b ready=%b want 1/0", wb_hold, lu_ready); else passed++;
        checks++; if (rf_write_address !== 5'd10 || rf_write_data !== 32'd1)
            $display("FAIL b2b_deq0 got %0d/%h want 10/1", rf_write_address, rf_write_data); else passed++;
        @(negedge clock); #1;
        checks++; if (lu_ready !== 1'b1 || wb_hold !== 1'b0) $display("FAIL b2b_c6 got ready=%b hold=%b want 1/0", lu_ready, wb_hold); else passed++;
        checks++; if (pending_mask !== 32'h0000_0800) $display("FAIL b2b_mask_c6 got %h want 00000800", pending_mask); else passed++;
        @(negedge clock); lu_valid = 1'b0; wb_write_enabled = 1'b0; #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd11 || rf_write_data !== 32'd2)
            $display("FAIL b2b_deq1 got %b/%0d/%h want 1/11/2", rf_write_enabled, rf_write_address, rf_write_data); else passed++;
        @(negedge clock); #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd12 || rf_write_data !== 32'd3)
            $display("FAIL b2b_deq2 got %b/%0d/%h want 1/12/3", rf_write_enabled, rf_write_address, rf_write_data); else passed++;
        @(negedge clock); #1;
        checks++; if (rf_write_enabled !== 1'b0 || pending_mask !== 32'h0)
            $display("FAIL b2b_drained got we=%b mask=%h want 0/0", rf_write_enabled, pending_mask); else passed++;
    endtask

    task automatic test_r0();
        wb_write_enabled = 1'b0; lu_valid = 1'b1; lu_write_address = 5'd0; lu_write_data = 32'hFF; #1;
        checks++; if (lu_ready !== 1'b1) $display("FAIL r0_ready got %b want 1", lu_ready); else passed++;
        checks++; if (rf_write_enabled !== 1'b0) $display("FAIL r0_we_same got %b want 0", rf_write_enabled); else passed++;
        @(negedge clock); lu_valid = 1'b0; #1;
        checks++; if (rf_write_enabled !== 1'b0) $display("FAIL r0_we_next got %b want 0", rf_write_enabled); else passed++;
        checks++; if (pending_mask !== 32'h0) $display("FAIL r0_mask got %h want 0", pending_mask); else passed++;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        wb_busy(); lu_valid = 1'b1; lu_write_address = 5'd20; lu_write_data = 32'h20;
        @(negedge clock); lu_write_address = 5'd21; lu_write_data = 32'h21;
        @(negedge clock); lu_valid = 1'b0; #1;
        checks++; if (pending_mask !== 32'h0030_0000) $display("FAIL rstmid_mask_pre got %h want 00300000", pending_mask); else passed++;
        reset_n = 1'b0; #1;
        checks++; if (pending_mask !== 32'h0) $display("FAIL rstmid_mask got %h want 0", pending_mask); else passed++;
        checks++; if (rf_write_enabled !== 1'b0) $display("FAIL rstmid_we got %b want 0", rf_write_enabled); else passed++;
        checks++; if (lu_ready !== 1'b0) $display("FAIL rstmid_ready got %b want 0", lu_ready); else passed++;
        @(negedge clock); reset_n = 1'b1; wb_write_enabled = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock); #1;
            checks++; if (rf_write_enabled !== 1'b0 || pending_mask !== 32'h0 || lu_ready !== 1'b1)
                $display("FAIL rstmid_after%0d got we=%b mask=%h ready=%b want 0/0/1", c, rf_write_enabled, pending_mask, lu_ready); else passed++;
        end
    endtask

    initial begin
        reset_n = 1'b0; wb_write_enabled = 1'b0; wb_write_address = '0; wb_write_strobe = '0;
        wb_write_data = '0; lu_valid = 1'b0; lu_write_address = '0; lu_write_data = '0;
        test_reset();
        @(negedge clock);
`ifndef RF_ARB_BYPASS_EN
        test_lu_basic();
`else
        test_bypass();
`endif
        @(negedge clock);
        test_starve();
        @(negedge clock); wb_write_enabled = 1'b0; @(negedge clock);
        test_back_to_back();
        test_r0();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
